// File: rtl/adler32_pkt_feeder_if.sv
// Stream/core bundle for the adler32 packet feeder.
// Upstream: in_valid/in_ready/in_data/in_last byte stream with end-of-packet flag.
// Core side: size_valid/size, data_start/data burst, checksum_valid, busy, overflow.
interface adler32_pkt_feeder_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        size_valid;
   logic [31:0] size;
   logic        data_start;
   logic [7:0]  data;
   logic        checksum_valid;
   logic        busy;
   logic        overflow;

   // Feeder side
   modport slave (
      input  in_valid, in_data, in_last, checksum_valid,
      output in_ready, size_valid, size, data_start, data, busy, overflow
   );

   // Upstream source plus checksum core, as seen from outside the feeder
   modport master (
      output in_valid, in_data, in_last, checksum_valid,
      input  in_ready, size_valid, size, data_start, data, busy, overflow
   );
endinterface

// File: rtl/adler32_pkt_feeder.sv
// Buffers one byte packet, then hands it to the adler32 core as size pulse + contiguous byte burst.
// Latency: size_valid the cycle after the last byte is taken; bytes follow one per clock with no bubbles.
// Backpressure: in_ready low from size_valid until checksum_valid; oversize packets are drained and dropped.
// Ports: clk, rst_n (async active-low), bus (adler32_pkt_feeder_if.slave: stream in, core interface out).
module adler32_pkt_feeder #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   adler32_pkt_feeder_if.slave bus
);

   typedef enum logic [2:0] {COLLECT, SIZE, STREAM, WAIT_CS, DROP} state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   rd_q, rd_d;
   logic [31:0]   size_q, size_d;
   logic          size_valid_q, size_valid_d;
   logic [7:0]    data_q, data_d;
   logic          data_start_q, data_start_d;
   logic          overflow_q, overflow_d;

   logic [7:0]    mem [DEPTH];
   logic          accept;
   logic          wr_en;
   logic [AW:0]   count_inc;
   logic [7:0]    rd_data;

   assign bus.in_ready   = (state_q == COLLECT) || (state_q == DROP);
   assign bus.busy       = (state_q == SIZE) || (state_q == STREAM) || (state_q == WAIT_CS);
   assign bus.size_valid = size_valid_q;
   assign bus.size       = size_q;
   assign bus.data_start = data_start_q;
   assign bus.data       = data_q;
   assign bus.overflow   = overflow_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign wr_en     = accept && (state_q == COLLECT);
   assign count_inc = count_q + 1'b1;
   // count never exceeds DEPTH-1 while writing, so the low AW bits address the buffer
   assign rd_data   = mem[rd_q[AW-1:0]];

   // Packet buffer: no reset, contents are only meaningful below count_q
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[count_q[AW-1:0]] <= bus.in_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      rd_d         = rd_q;
      size_d       = size_q;
      size_valid_d = 1'b0;
      data_d       = data_q;
      data_start_d = 1'b0;
      overflow_d   = 1'b0;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               count_d = count_inc;
               if (bus.in_last) begin
                  state_d      = SIZE;
                  size_valid_d = 1'b1;
                  size_d       = 32'(count_inc);
               end else if (count_inc == DEPTH_C) begin
                  // Buffer full with more to come: drain the rest of this packet
                  overflow_d = 1'b1;
                  count_d    = '0;
                  state_d    = DROP;
               end
            end
         end
         SIZE: begin
            // rd_q is 0 here; byte 0 goes out together with data_start
            state_d      = STREAM;
            data_d       = rd_data;
            data_start_d = 1'b1;
            rd_d         = rd_q + 1'b1;
         end
         STREAM: begin
            // rd_q is the index of the next byte; the burst ends once it reaches count
            if (rd_q == count_q) begin
               state_d = WAIT_CS;
            end else begin
               data_d = rd_data;
               rd_d   = rd_q + 1'b1;
            end
         end
         WAIT_CS: begin
            if (bus.checksum_valid) begin
               state_d = COLLECT;
               count_d = '0;
               rd_d    = '0;
            end
         end
         DROP: begin
            if (accept && bus.in_last) begin
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         count_q      <= '0;
         rd_q         <= '0;
         size_q       <= '0;
         size_valid_q <= 1'b0;
         data_q       <= '0;
         data_start_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         rd_q         <= rd_d;
         size_q       <= size_d;
         size_valid_q <= size_valid_d;
         data_q       <= data_d;
         data_start_q <= data_start_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_adler32_pkt_feeder.sv
// Directed bench for adler32_pkt_feeder: packet buffering, size/data burst timing,
// hold-off until checksum_valid, full-depth and oversize packets, input gaps, reset mid-stream.
module tb_adler32_pkt_feeder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   adler32_pkt_feeder_if ifc();

   adler32_pkt_feeder #(.DEPTH(256), .AW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ovf_cnt = 0;
   int sv_cnt = 0;

   logic [7:0] pkt [0:299];

   always @(negedge clk) begin
      if (ifc.overflow === 1'b1) ovf_cnt++;
      if (ifc.size_valid === 1'b1) sv_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte, wait (bounded) for in_ready, then let it be taken on the next edge
   task automatic drive_byte(input logic [7:0] d, input logic last);
      int t = 0;
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      ifc.in_last  = last;
      while (ifc.in_ready !== 1'b1 && t < 1000) begin
         step();
         t++;
      end
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", ifc.in_ready);
      end
      step();
      ifc.in_valid = 1'b0;
      ifc.in_last  = 1'b0;
   endtask

   task automatic send_pkt(input int len, input int gap);
      for (int i = 0; i < len; i++) begin
         drive_byte(pkt[i], logic'(i == len - 1));
         if (i != len - 1) repeat (gap) step();
      end
   endtask

   // Called right after the last byte is taken: size pulse now, burst on the following cycles
   task automatic check_stream(input string name, input int len);
      checks++;
      if (ifc.size_valid !== 1'b1 || ifc.size !== 32'(len)) begin
         errors++;
         $display("FAIL %s size: size_valid=%0b size=%0d required 1/%0d", name, ifc.size_valid, ifc.size, len);
      end
      checks++;
      if (ifc.busy !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.data_start !== 1'b0) begin
         errors++;
         $display("FAIL %s size_cycle: busy=%0b in_ready=%0b data_start=%0b required 1/0/0", name, ifc.busy, ifc.in_ready, ifc.data_start);
      end
      for (int k = 0; k < len; k++) begin
         step();
         checks++;
         if (ifc.data !== pkt[k] || ifc.data_start !== logic'(k == 0) || ifc.size_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s byte%0d: data=%02h start=%0b size_valid=%0b required %02h/%0b/0", name, k, ifc.data, ifc.data_start, ifc.size_valid, pkt[k], k == 0);
         end
      end
      step();
      checks++;
      if (ifc.data_start !== 1'b0 || ifc.data !== pkt[len-1] || ifc.busy !== 1'b1 || ifc.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s after_burst: start=%0b data=%02h busy=%0b in_ready=%0b required 0/%02h/1/0", name, ifc.data_start, ifc.data, ifc.busy, ifc.in_ready, pkt[len-1]);
      end
   endtask

   task automatic release_cs(input string name);
      ifc.checksum_valid = 1'b1;
      step();
      ifc.checksum_valid = 1'b0;
      checks++;
      if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: in_ready=%0b busy=%0b required 1/0", name, ifc.in_ready, ifc.busy);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (ifc.size_valid !== 1'b0 || ifc.size !== 32'd0 || ifc.data_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_size: size_valid=%0b size=%0d data_start=%0b required 0/0/0", ifc.size_valid, ifc.size, ifc.data_start);
      end
      checks++;
      if (ifc.data !== 8'h00 || ifc.busy !== 1'b0 || ifc.overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: data=%02h busy=%0b overflow=%0b required 00/0/0", ifc.data, ifc.busy, ifc.overflow);
      end
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%0b required 1", ifc.in_ready);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      pkt[0] = 8'h48; pkt[1] = 8'h65; pkt[2] = 8'h6C; pkt[3] = 8'h6C; pkt[4] = 8'h6F;
      send_pkt(5, 0);
      check_stream("hello", 5);
   endtask

   // Still in WAIT_CS from test_basic; the next packet is offered but must wait
   task automatic test_hold();
      ifc.in_valid = 1'b1;
      ifc.in_data  = 8'h11;
      ifc.in_last  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold cycle%0d: in_ready=%0b busy=%0b required 0/1", i, ifc.in_ready, ifc.busy);
         end
      end
      ifc.checksum_valid = 1'b1;
      checks++;
      if (ifc.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL hold cs_cycle: in_ready=%0b required 0", ifc.in_ready);
      end
      step();
      ifc.checksum_valid = 1'b0;
      checks++;
      if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL hold release: in_ready=%0b busy=%0b required 1/0", ifc.in_ready, ifc.busy);
      end
      pkt[0] = 8'h11; pkt[1] = 8'h22;
      send_pkt(2, 0);
      check_stream("hold_next", 2);
      release_cs("hold_next");
   endtask

   task automatic test_full_depth();
      int o;
      o = ovf_cnt;
      for (int i = 0; i < 256; i++) pkt[i] = 8'(i);
      send_pkt(256, 0);
      check_stream("full", 256);
      checks++;
      if (ovf_cnt !== o) begin
         errors++;
         $display("FAIL full overflow_pulses: got=%0d required %0d", ovf_cnt - o, 0);
      end
      release_cs("full");
   endtask

   task automatic test_overflow();
      int s;
      int o;
      s = sv_cnt;
      o = ovf_cnt;
      for (int i = 0; i < 256; i++) drive_byte(8'(i), 1'b0);
      checks++;
      if (ifc.overflow !== 1'b1 || ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ovf pulse: overflow=%0b in_ready=%0b required 1/1", ifc.overflow, ifc.in_ready);
      end
      drive_byte(8'h55, 1'b1);
      checks++;
      if (ifc.overflow !== 1'b0 || ifc.size_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ovf drop_last: overflow=%0b size_valid=%0b busy=%0b in_ready=%0b required 0/0/0/1", ifc.overflow, ifc.size_valid, ifc.busy, ifc.in_ready);
      end
      repeat (3) step();
      checks++;
      if (sv_cnt !== s || ovf_cnt !== o + 1) begin
         errors++;
         $display("FAIL ovf counts: size_pulses=%0d overflow_pulses=%0d required 0/1", sv_cnt - s, ovf_cnt - o);
      end
      pkt[0] = 8'hAB;
      send_pkt(1, 0);
      check_stream("after_drop", 1);
      release_cs("after_drop");
   endtask

   task automatic test_gaps();
      pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
      send_pkt(3, 2);
      check_stream("gaps", 3);
      release_cs("gaps");
   endtask

   task automatic test_reset_mid();
      int s;
      for (int i = 0; i < 10; i++) pkt[i] = 8'hA0 + 8'(i);
      send_pkt(10, 0);
      repeat (5) step();
      checks++;
      if (ifc.data !== 8'hA4) begin
         errors++;
         $display("FAIL rstmid k4: data=%02h required a4", ifc.data);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ifc.data !== 8'h00 || ifc.data_start !== 1'b0 || ifc.size_valid !== 1'b0 || ifc.size !== 32'd0 || ifc.busy !== 1'b0 || ifc.overflow !== 1'b0) begin
         errors++;
         $display("FAIL rstmid outputs: data=%02h start=%0b sv=%0b size=%0d busy=%0b ovf=%0b required all 0", ifc.data, ifc.data_start, ifc.size_valid, ifc.size, ifc.busy, ifc.overflow);
      end
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid ready: in_ready=%0b required 1", ifc.in_ready);
      end
      step();
      step();
      rst_n = 1'b1;
      s = sv_cnt;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (ifc.data_start !== 1'b0 || ifc.data !== 8'h00 || ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid idle%0d: start=%0b data=%02h in_ready=%0b required 0/00/1", i, ifc.data_start, ifc.data, ifc.in_ready);
         end
      end
      checks++;
      if (sv_cnt !== s) begin
         errors++;
         $display("FAIL rstmid size_pulses: got=%0d required 0", sv_cnt - s);
      end
      pkt[0] = 8'h5A; pkt[1] = 8'hC3; pkt[2] = 8'h0F;
      send_pkt(3, 0);
      check_stream("post_reset", 3);
      release_cs("post_reset");
   endtask

   initial begin
      ifc.in_valid       = 1'b0;
      ifc.in_data        = 8'h00;
      ifc.in_last        = 1'b0;
      ifc.checksum_valid = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_full_depth();
      test_overflow();
      test_gaps();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
